verinject_ff_mode_injector: RTL

- Parametrised successor to the single-mode flip-flop XOR injector. It sits on one register's output path: `modified` equals `unmodified` except where faults are applied.
- Adds stuck-at-0, stuck-at-1 and timed transient fault modes, with a configurable number of concurrent timed-fault slots.
- Driven by the shared `verinject__injector_state` bus plus mode and duration side-band inputs from the injection controller.

---
 rtl/verinject_ff_mode_injector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/verinject_ff_mode_injector.sv
// Multi-mode fault injector on one register's output path: persistent XOR flips plus
// timed stuck-at-0 / stuck-at-1 / transient faults held in a small pool of slots.

module verinject_ff_mode_slot #(
  parameter int IDX_W = 3,
  parameter int DUR_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_alloc,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [1:0]       i_mode,
  input  logic [DUR_W-1:0] i_dur,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_idx,
  output logic [1:0]       o_mode
);
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [DUR_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_mode  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_alloc) begin
          w_state_nxt = S_HOLD;
          w_idx_nxt   = i_idx;
          w_mode_nxt  = i_mode;
          // A zero-length transient still shows for one cycle
          w_cnt_nxt   = (i_mode == 2'd3 && i_dur == '0) ? DUR_W'(1) : i_dur;
        end
      end
      S_HOLD: begin
        // Counter 0 is a permanent stuck fault: never decrements, never releases
        if (r_cnt == DUR_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DUR_W'(1);
        end
      end
    endcase
  end

  assign o_busy = (r_state == S_HOLD);
  assign o_idx  = r_idx;
  assign o_mode = r_mode;
endmodule

module verinject_ff_mode_injector #(
  parameter int LEFT      = 0,
  parameter int RIGHT     = 0,
  parameter int P_START   = 0,
  parameter int NUM_SLOTS = 2,
  parameter int DUR_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 do_write,
  input  logic [LEFT:RIGHT]    unmodified,
  output logic [LEFT:RIGHT]    modified,
  input  logic [31:0]          verinject__injector_state,
  input  logic [1:0]           verinject__injector_mode,
  input  logic [DUR_W-1:0]     verinject__injector_duration,
  output logic                 fault_active,
  output logic [7:0]           drop_count
);
  localparam int WL    = ((LEFT > RIGHT) ? (LEFT - RIGHT) : (RIGHT - LEFT)) + 1;
  localparam int BS    = (LEFT < RIGHT) ? LEFT : RIGHT;
  localparam int IDX_W = (WL > 1) ? $clog2(WL) : 1;

  localparam logic [1:0] M_FLIP   = 2'd0;
  localparam logic [1:0] M_STUCK0 = 2'd1;
  localparam logic [1:0] M_STUCK1 = 2'd2;
  localparam logic [1:0] M_TRANS  = 2'd3;

  // Masks are held by offset from bits_start so either range direction maps the same way
  logic [WL-1:0]                      r_xor;
  logic [WL-1:0]                      w_ev_oh, w_s0, w_s1, w_t;
  logic [32:0]                        w_off;
  logic                               w_in_range, w_flip_ev, w_timed_ev, w_found, w_drop;
  logic [IDX_W-1:0]                   w_idx;
  logic [NUM_SLOTS-1:0]               w_grant, w_busy;
  logic [NUM_SLOTS-1:0][IDX_W-1:0]    w_sidx;
  logic [NUM_SLOTS-1:0][1:0]          w_smode;

  assign w_off      = {1'b0, verinject__injector_state} - 33'(P_START);
  assign w_in_range = ({1'b0, verinject__injector_state} >= 33'(P_START)) && (w_off < 33'(WL));
  assign w_idx      = IDX_W'(w_off);
  assign w_flip_ev  = w_in_range && (verinject__injector_mode == M_FLIP);
  assign w_timed_ev = w_in_range && (verinject__injector_mode != M_FLIP);

  always_comb begin
    w_ev_oh = '0;
    for (int k = 0; k < WL; k++) w_ev_oh[k] = (w_idx == IDX_W'(k));
  end

  // Lowest-indexed idle slot wins; a slot releasing this edge still counts as busy
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_timed_ev && !w_busy[s] && !w_found) begin
        w_grant[s] = 1'b1;
        w_found    = 1'b1;
      end
    end
    w_drop = w_timed_ev && !w_found;
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    verinject_ff_mode_slot #(.IDX_W(IDX_W), .DUR_W(DUR_W)) u_slot (
      .clock  (clock),
      .reset  (reset),
      .i_alloc(w_grant[s]),
      .i_idx  (w_idx),
      .i_mode (verinject__injector_mode),
      .i_dur  (verinject__injector_duration),
      .o_busy (w_busy[s]),
      .o_idx  (w_sidx[s]),
      .o_mode (w_smode[s])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_xor      <= '0;
      drop_count <= '0;
    end else begin
      r_xor <= (do_write ? '0 : r_xor) ^ (w_flip_ev ? w_ev_oh : '0);
      if (w_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    w_s0 = '0;
    w_s1 = '0;
    w_t  = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int k = 0; k < WL; k++) begin
        if (w_busy[s] && w_sidx[s] == IDX_W'(k)) begin
          case (w_smode[s])
            M_STUCK0: w_s0[k] = 1'b1;
            M_STUCK1: w_s1[k] = 1'b1;
            M_TRANS:  w_t[k]  = ~w_t[k];
            default:  ;
          endcase
        end
      end
    end
  end

  for (genvar k = 0; k < WL; k++) begin : g_bit
    assign modified[BS+k] = ((unmodified[BS+k] ^ r_xor[k] ^ w_t[k]) & ~w_s0[k]) | w_s1[k];
  end

  assign fault_active = (r_xor != '0) || (w_busy != '0);
endmodule
